sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter.sv | 110 +++++++++++
 tb/tb_sqrt_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one square-root engine between four requesters,
// with a watchdog that turns a hung engine job into an error response.
module sqrt_arbiter #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] din,
    output logic [3:0]  ack,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        eng_start,
    output logic [15:0] eng_din,
    input  logic        eng_busy,
    input  logic [15:0] eng_dout
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  last;
    logic [7:0]  cnt;
    logic        gnt_valid;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic        first_run;
    logic        done;
    logic        expired;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        cand      = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // The engine only raises eng_busy the cycle after start, so the first RUN cycle is blind.
    assign first_run = (cnt == 8'd0);
    assign done      = !first_run && !eng_busy;
    assign expired   = (cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = RUN;
            RUN:     if (done || expired) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response handshake: rsp_valid holds with stable id/data/err until a cycle with rsp_ready=1.
    assign ack       = (state == IDLE && gnt_valid) ? (4'b0001 << gnt_idx) : 4'b0000;
    assign busy      = (state != IDLE);
    assign eng_start = (state == LAUNCH);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 2'd3;
            cnt      <= 8'd0;
            eng_din  <= 16'h0000;
            rsp_id   <= 2'd0;
            rsp_data <= 16'h0000;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        eng_din <= din[{gnt_idx, 4'b0000} +: 16];
                        rsp_id  <= gnt_idx;
                        last    <= gnt_idx;
                    end
                end
                LAUNCH: cnt <= 8'd0;
                RUN: begin
                    cnt <= cnt + 8'd1;
                    // Normal completion wins over a watchdog expiry in the same cycle.
                    if (done) begin
                        rsp_data <= eng_dout;
                        rsp_err  <= 1'b0;
                    end else if (expired) begin
                        rsp_data <= 16'h0000;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: behavioural engine model, expected-response queue,
// immediate assertions at every comparison point.
module tb_sqrt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] din;
    logic [3:0]  ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        eng_start;
    logic [15:0] eng_din;
    logic        eng_busy;
    logic [15:0] eng_dout;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_start  = 0;
    int          n_overlap = 0;
    logic [18:0] exp_q[$];

    int          model_lat   = 20;
    logic        model_stuck = 1'b0;
    logic [15:0] model_key   = 16'h0000;
    logic [15:0] eng_cap;
    int          eng_left;

    logic [3:0]  fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int          grants;
    int          cyc;

    sqrt_arbiter #(.TIMEOUT(63)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_din   (eng_din),
        .eng_busy  (eng_busy),
        .eng_dout  (eng_dout)
    );

    // Clock and global time limit
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Engine model: busy for model_lat cycles after start, result = operand ^ model_key
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_dout <= 16'h0000;
            eng_cap  <= 16'h0000;
            eng_left <= 0;
        end else if (eng_start) begin
            eng_busy <= 1'b1;
            eng_cap  <= eng_din;
            eng_left <= model_lat;
        end else if (eng_busy && !model_stuck) begin
            if (eng_left <= 1) begin
                eng_busy <= 1'b0;
                eng_dout <= eng_cap ^ model_key;
            end else begin
                eng_left <= eng_left - 1;
            end
        end
    end

    always @(posedge clk) if (eng_start) n_start++;
    always @(negedge clk) if (eng_start && eng_busy) n_overlap++;

    // Driver helpers: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},       32'(ack),       32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'h0);
        chk({tag, "_eng_din"},   32'(eng_din),   32'h0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
    endtask

    // Scoreboard: compare the presented response against the oldest expected one
    task automatic check_rsp(input string tag);
        logic [18:0] e;
        chk({tag, "_queued"}, 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, {13'h0, rsp_id, rsp_err, rsp_data}, {13'h0, e});
        end
    endtask

    // Called right after a sample; returns the number of further cycles until rsp_valid
    task automatic wait_rsp(input string tag, input int budget, output int waited);
        waited = 0;
        while (!rsp_valid && waited < budget) begin
            next_cycle();
            sample();
            waited++;
        end
        chk({tag, "_seen"}, 32'(rsp_valid), 32'h1);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        din       = 64'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        chk_zero("reset");
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single job: 20-cycle engine, result ABCD
        model_lat  = 20;
        model_key  = 16'h1234 ^ 16'hABCD;
        rsp_ready  = 1'b1;
        din[15:0]  = 16'h1234;
        req        = 4'b0001;
        exp_q.push_back({2'd0, 1'b0, 16'hABCD});
        sample();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_busy_idle", 32'(busy), 32'h0);
        next_cycle();
        req = 4'b0000;
        sample();
        chk("single_start", 32'(eng_start), 32'h1);
        chk("single_eng_din", 32'(eng_din), 32'h1234);
        chk("single_ack_launch", 32'(ack), 32'h0);
        next_cycle();
        sample();
        chk("single_start_once", 32'(eng_start), 32'h0);
        chk("single_busy_run", 32'(busy), 32'h1);
        wait_rsp("single", 60, cyc);
        chk("single_latency", cyc, 21);
        check_rsp("single_rsp");
        chk("single_start_count", n_start, 1);
        next_cycle();
        sample();
        chk("single_idle_valid", 32'(rsp_valid), 32'h0);
        chk("single_idle_busy", 32'(busy), 32'h0);

        // Fairness from reset with all four requesting
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        model_lat = 3;
        model_key = 16'h5A5A;
        din       = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req       = 4'b1111;
        grants    = 0;
        cyc       = 0;
        while ((grants < 5 || exp_q.size() > 0) && cyc < 200) begin
            sample();
            if (ack != 4'b0000 && grants < 5) begin
                chk("fair_ack", 32'(ack), 32'(fair_exp[grants]));
                exp_q.push_back({2'(grants % 4), 1'b0, din[16*(grants % 4) +: 16] ^ model_key});
                grants++;
            end
            if (rsp_valid) check_rsp("fair_rsp");
            next_cycle();
            if (grants == 5) req = 4'b0000;
            cyc++;
        end
        chk("fair_grants", grants, 5);

        // Watchdog: engine never finishes
        model_stuck = 1'b1;
        din[47:32]  = 16'h0900;
        req         = 4'b0100;
        exp_q.push_back({2'd2, 1'b1, 16'h0000});
        sample();
        chk("tmo_ack", 32'(ack), 32'h4);
        next_cycle();
        req = 4'b0000;
        sample();
        next_cycle();
        sample();
        wait_rsp("tmo", 100, cyc);
        chk("tmo_latency", cyc, 63);
        check_rsp("tmo_rsp");
        next_cycle();
        model_stuck = 1'b0;
        repeat (5) next_cycle();
        sample();
        chk("tmo_idle_busy", 32'(busy), 32'h0);

        // Engine finishes in the very cycle the watchdog would expire
        next_cycle();
        model_lat  = 62;
        din[63:48] = 16'h7777;
        req        = 4'b1000;
        exp_q.push_back({2'd3, 1'b0, 16'h7777 ^ 16'h5A5A});
        sample();
        chk("edge_ack", 32'(ack), 32'h8);
        next_cycle();
        req = 4'b0000;
        sample();
        next_cycle();
        sample();
        wait_rsp("edge", 100, cyc);
        chk("edge_latency", cyc, 63);
        check_rsp("edge_rsp");

        // Backpressure with requester 1 waiting
        next_cycle();
        model_lat = 3;
        rsp_ready = 1'b0;
        din[15:0] = 16'h00F0;
        req       = 4'b0001;
        exp_q.push_back({2'd0, 1'b0, 16'h5AAA});
        sample();
        chk("bp_ack0", 32'(ack), 32'h1);
        next_cycle();
        req        = 4'b0010;
        din[31:16] = 16'h0BAD;
        sample();
        chk("bp_ack_launch", 32'(ack), 32'h0);
        next_cycle();
        sample();
        wait_rsp("bp", 20, cyc);
        check_rsp("bp_rsp");
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            sample();
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_fields", {13'h0, rsp_id, rsp_err, rsp_data}, {13'h0, 2'd0, 1'b0, 16'h5AAA});
            chk("bp_hold_ack", 32'(ack), 32'h0);
            chk("bp_hold_busy", 32'(busy), 32'h1);
        end
        next_cycle();
        rsp_ready = 1'b1;
        sample();
        chk("bp_release_ack", 32'(ack), 32'h0);
        next_cycle();
        sample();
        chk("bp_grant1", 32'(ack), 32'h2);
        exp_q.push_back({2'd1, 1'b0, 16'h51F7});
        next_cycle();
        req = 4'b0000;
        sample();
        wait_rsp("bp2", 20, cyc);
        check_rsp("bp2_rsp");

        // Reset in the middle of RUN, then a fresh job
        next_cycle();
        model_lat  = 20;
        din[47:32] = 16'h1111;
        req        = 4'b0100;
        sample();
        chk("rr_ack", 32'(ack), 32'h4);
        next_cycle();
        req = 4'b0000;
        repeat (3) next_cycle();
        rst = 1'b1;
        sample();
        chk_zero("midrun_reset");
        next_cycle();
        rst        = 1'b0;
        din[63:48] = 16'h2222;
        req        = 4'b1000;
        exp_q.push_back({2'd3, 1'b0, 16'h2222 ^ 16'h5A5A});
        sample();
        chk("post_reset_ack", 32'(ack), 32'h8);
        next_cycle();
        req = 4'b0000;
        sample();
        wait_rsp("post_reset", 40, cyc);
        check_rsp("post_reset_rsp");
        chk("queue_drained", exp_q.size(), 0);
        chk("start_while_busy", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
